// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: silence-delimited framing, CRC-16/MODBUS check, ready/ack hand-off.
// Optional slave-address filtering is enabled by defining MODBUS_ADDR_FILTER_EN.
module modbus_rtu_rx_framer #(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = 9,
  parameter int T15     = 17,
  parameter int T35     = 39
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_tick,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_err,
  input  logic [7:0]       my_addr,
  input  logic [7:0]       buf_raddr,
  output logic [7:0]       buf_rdata,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_ready,
  input  logic             frame_ack,
  output logic             frame_drop,
  output logic             rx_overrun
);

  localparam int CNT_W = $clog2(T35 + 1);
  localparam int AW    = $clog2(MAX_LEN);

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_RECV, S_GAP, S_CHECK, S_HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   sil_cnt;
  logic [15:0]        crc;
  logic [LEN_W-1:0]   len;
  logic               bad;
  logic               ovf;
  logic [7:0]         mem [MAX_LEN];
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic               cnt_full;
  logic               addr_ok;
  logic               frame_ok;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c_in, input logic [7:0] d);
    logic [15:0] c;
    c = c_in ^ {8'h00, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

`ifdef MODBUS_ADDR_FILTER_EN
  logic [7:0] first_byte;
  assign addr_ok = (first_byte == my_addr) || (first_byte == 8'h00);
`else
  logic unused_my_addr;
  assign unused_my_addr = ^my_addr;
  assign addr_ok        = 1'b1;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = len[AW-1:0];
    cnt_full = (sil_cnt == CNT_W'(T35));
    frame_ok = !bad && !ovf && (len >= LEN_W'(4)) && (crc == 16'h0000) && addr_ok;
    if (rx_valid && state == S_IDLE) begin
      wr_en   = 1'b1;
      wr_addr = '0;
    end else if (rx_valid && state == S_RECV && len < LEN_W'(MAX_LEN)) begin
      wr_en = 1'b1;
    end
  end

  // NOTE: the byte buffer has no reset; its contents are only meaningful while frame_ready is high.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= rx_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_SYNC;
      sil_cnt     <= '0;
      crc         <= 16'hFFFF;
      len         <= '0;
      bad         <= 1'b0;
      ovf         <= 1'b0;
      buf_rdata   <= '0;
      frame_len   <= '0;
      frame_ready <= 1'b0;
      frame_drop  <= 1'b0;
      rx_overrun  <= 1'b0;
`ifdef MODBUS_ADDR_FILTER_EN
      first_byte  <= '0;
`endif
    end else begin
      frame_drop <= 1'b0;
      rx_overrun <= 1'b0;
      buf_rdata  <= mem[buf_raddr];

      // A received byte restarts the silence measurement even if a tick lands on the same cycle.
      if (rx_valid)
        sil_cnt <= '0;
      else if (bit_tick && !cnt_full)
        sil_cnt <= sil_cnt + CNT_W'(1);

      case (state)
        S_SYNC: if (cnt_full) state <= S_IDLE;
        S_IDLE: begin
          if (rx_valid) begin
            len   <= LEN_W'(1);
            crc   <= crc16_upd(16'hFFFF, rx_data);
            bad   <= rx_err;
            ovf   <= 1'b0;
`ifdef MODBUS_ADDR_FILTER_EN
            first_byte <= rx_data;
`endif
            state <= S_RECV;
          end
        end
        S_RECV: begin
          if (rx_valid) begin
            if (len < LEN_W'(MAX_LEN)) begin
              crc <= crc16_upd(crc, rx_data);
              bad <= bad | rx_err;
              len <= len + LEN_W'(1);
            end else begin
              ovf <= 1'b1;
            end
          end else if (sil_cnt >= CNT_W'(T15)) begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (rx_valid) begin
            frame_drop <= 1'b1;
            state      <= S_SYNC;
          end else if (cnt_full) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (frame_ok) begin
            frame_ready <= 1'b1;
            frame_len   <= len;
            state       <= S_HOLD;
          end else begin
            frame_drop <= 1'b1;
            state      <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (rx_valid) rx_overrun <= 1'b1;
          if (frame_ack) begin
            frame_ready <= 1'b0;
            state       <= (cnt_full && !rx_valid) ? S_IDLE : S_SYNC;
          end
        end
        default: state <= S_SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
// Self-checking bench for modbus_rtu_rx_framer: directed frame table, corner sequences, random frames.
// Frame acceptance is predicted from the framing rules and a byte-level CRC-16/MODBUS model.
module tb_modbus_rtu_rx_framer;
  localparam int MAX_LEN = 256;
  localparam int LEN_W   = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             bit_tick;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_err;
  logic [7:0]       my_addr;
  logic [7:0]       buf_raddr;
  logic [7:0]       buf_rdata;
  logic [LEN_W-1:0] frame_len;
  logic             frame_ready;
  logic             frame_ack;
  logic             frame_drop;
  logic             rx_overrun;

  modbus_rtu_rx_framer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .T15(17), .T35(39)) dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_err(rx_err), .my_addr(my_addr), .buf_raddr(buf_raddr), .buf_rdata(buf_rdata),
    .frame_len(frame_len), .frame_ready(frame_ready), .frame_ack(frame_ack),
    .frame_drop(frame_drop), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] bytes;    // right-aligned, first transmitted byte is the leftmost
    logic [7:0]  n;
    logic        add_crc;
    logic [7:0]  err_at;   // 8'hFF: no rx_err
    logic        exp_ready;
  } vec_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         drop_cnt = 0;
  int         ovr_cnt  = 0;
  logic [7:0] tx [0:299];
  int         tx_n;
  int         tx_err_at;
  vec_t       vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic tick, input logic valid, input logic [7:0] d, input logic err);
    bit_tick = tick;
    rx_valid = valid;
    rx_data  = d;
    rx_err   = err;
    @(posedge clk);
    #1;
    if (frame_drop) drop_cnt++;
    if (rx_overrun) ovr_cnt++;
    bit_tick  = 1'b0;
    rx_valid  = 1'b0;
    rx_err    = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0);
    end
  endtask

  // Silence long enough to leave SYNC, then settle into IDLE.
  task automatic resync();
    idle_ticks(39);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  function automatic logic [15:0] crc16(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {8'h00, tx[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic append_crc();
    logic [15:0] c;
    c = crc16(tx_n);
    tx[tx_n]     = c[7:0];
    tx[tx_n + 1] = c[15:8];
    tx_n += 2;
  endtask

  function automatic logic addr_ok();
`ifdef MODBUS_ADDR_FILTER_EN
    return (tx[0] == my_addr) || (tx[0] == 8'h00);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic model_ok();
    logic err_in_frame;
    err_in_frame = (tx_err_at >= 0) && (tx_err_at < tx_n);
    return !err_in_frame && (tx_n >= 4) && (tx_n <= MAX_LEN) && (crc16(tx_n) == 16'h0000) && addr_ok();
  endfunction

  task automatic load_test1();
    logic [63:0] f;
    f = 64'h01030000_0001840A;
    tx_n = 8;
    tx_err_at = -1;
    for (int i = 0; i < 8; i++) tx[i] = f[(7 - i) * 8 +: 8];
  endtask

  task automatic send_tx(input int gmin, input int gmax);
    for (int i = 0; i < tx_n; i++) begin
      step(1'b0, 1'b1, tx[i], i == tx_err_at);
      if (i != tx_n - 1) idle_ticks($urandom_range(gmax, gmin));
    end
  endtask

  task automatic check_buf(input string tag);
    int mism;
    mism = 0;
    for (int i = 0; i < tx_n; i++) begin
      buf_raddr = 8'(i);
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (buf_rdata !== tx[i]) mism++;
    end
    check({tag, " buf bytes wrong"}, 32'(mism), 32'd0);
  endtask

  // Sends tx[] from IDLE, checks the acceptance decision, contents and the ack hand-off.
  task automatic run_frame(input string tag, input logic exp_ok, input int gmin, input int gmax,
                           input logic do_ack);
    int d0;
    d0 = drop_cnt;
    send_tx(gmin, gmax);
    idle_ticks(39);
    check({tag, " ready early"}, 32'(frame_ready), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check({tag, " ready"}, 32'(frame_ready), 32'(exp_ok));
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check({tag, " drops"}, 32'(drop_cnt - d0), 32'(!exp_ok));
    if (exp_ok) begin
      check({tag, " len"}, 32'(frame_len), 32'(tx_n));
      check_buf(tag);
      if (do_ack) begin
        frame_ack = 1'b1;
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check({tag, " ready after ack"}, 32'(frame_ready), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
      end
    end
  endtask

  initial begin
    int d0;
    int o0;
    logic exp;
    rst = 1'b1; bit_tick = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    my_addr = 8'h01; buf_raddr = 8'h00; frame_ack = 1'b0;

    vecs[0] = '{96'h01030000_0001840A, 8'd8, 1'b0, 8'hFF, 1'b1};
    vecs[1] = '{96'h01030000_0001840B, 8'd8, 1'b0, 8'hFF, 1'b0};
    vecs[2] = '{96'h010300,            8'd3, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{96'h0111,              8'd2, 1'b1, 8'hFF, 1'b1};
    vecs[4] = '{96'h01030000_0001840A, 8'd8, 1'b0, 8'd2,  1'b0};
    vecs[5] = '{96'h00060001_0003,     8'd6, 1'b1, 8'hFF, 1'b1};

    // Reset state
    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0);
    check("reset frame_ready", 32'(frame_ready), 32'd0);
    check("reset frame_len", 32'(frame_len), 32'd0);
    check("reset frame_drop", 32'(frame_drop), 32'd0);
    check("reset rx_overrun", 32'(rx_overrun), 32'd0);
    check("reset buf_rdata", 32'(buf_rdata), 32'd0);
    rst = 1'b0;

    // Bytes before the first full idle period are ignored silently
    d0 = drop_cnt; o0 = ovr_cnt;
    load_test1();
    send_tx(10, 10);
    idle_ticks(10);
    check("sync ignore drops", 32'(drop_cnt - d0), 32'd0);
    check("sync ignore overrun", 32'(ovr_cnt - o0), 32'd0);
    check("sync ignore ready", 32'(frame_ready), 32'd0);
    resync();

    // Directed table
    for (int v = 0; v < 6; v++) begin
      tx_n = int'(vecs[v].n);
      for (int i = 0; i < tx_n; i++) tx[i] = vecs[v].bytes[(tx_n - 1 - i) * 8 +: 8];
      if (vecs[v].add_crc) append_crc();
      tx_err_at = (vecs[v].err_at == 8'hFF) ? -1 : int'(vecs[v].err_at);
      run_frame($sformatf("vec%0d", v), vecs[v].exp_ready && addr_ok(), 10, 10, 1'b1);
    end

    // t1.5 violation: 20-tick gap after the third byte
    load_test1();
    d0 = drop_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, tx[i], 1'b0);
      idle_ticks(i == 2 ? 20 : 10);
    end
    step(1'b0, 1'b1, tx[3], 1'b0);
    check("gap violation drop", 32'(drop_cnt - d0), 32'd1);
    resync();
    run_frame("after gap", 1'b1, 10, 10, 1'b1);

    // Byte during HOLD
    load_test1();
    run_frame("hold", 1'b1, 10, 10, 1'b0);
    o0 = ovr_cnt;
    step(1'b0, 1'b1, 8'hEE, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("hold overrun pulse", 32'(ovr_cnt - o0), 32'd1);
    check("hold ready kept", 32'(frame_ready), 32'd1);
    check("hold len kept", 32'(frame_len), 32'd8);
    check_buf("hold");
    frame_ack = 1'b1;
    step(1'b0, 1'b0, 8'h00, 1'b0);
    check("hold ack ready", 32'(frame_ready), 32'd0);
    resync();

    // Address filter
    my_addr = 8'h02;
    load_test1();
`ifdef MODBUS_ADDR_FILTER_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    run_frame("addr 02", exp, 10, 10, 1'b1);
    my_addr = 8'h01;
    load_test1();
    run_frame("addr 01", 1'b1, 10, 10, 1'b1);

    // Randomized frames against the model
    for (int r = 0; r < 25; r++) begin
      int sel;
      tx_n = $urandom_range(12, 1);
      for (int i = 0; i < tx_n; i++) tx[i] = 8'($urandom);
      sel = $urandom_range(3, 0);
      if (sel < 2) tx[0] = my_addr;
      else if (sel == 2) tx[0] = 8'h00;
      if ($urandom_range(3, 0) != 0) append_crc();
      if ($urandom_range(4, 0) == 0) tx[$urandom_range(tx_n - 1, 0)] ^= 8'h10;
      tx_err_at = ($urandom_range(7, 0) == 0) ? $urandom_range(tx_n - 1, 0) : -1;
      run_frame($sformatf("rand%0d", r), model_ok(), 10, 16, 1'b1);
    end

    // Length boundary: exactly MAX_LEN accepted, one more overflows
    tx_n = MAX_LEN - 2;
    for (int i = 0; i < tx_n; i++) tx[i] = 8'($urandom);
    tx[0] = my_addr;
    tx_err_at = -1;
    append_crc();
    run_frame("max len", model_ok(), 0, 0, 1'b1);
    tx_n = MAX_LEN - 1;
    for (int i = 0; i < tx_n; i++) tx[i] = 8'($urandom);
    tx[0] = my_addr;
    append_crc();
    run_frame("over len", model_ok(), 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
